div_ctrl: RTL and testbench

//  Sequencer between the RV32M issue logic and the shared div32 unit. Handles DIV/DIVU/REM/REMU.

---
 rtl/div_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_div_ctrl.sv | 472 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_ctrl.sv
// div_ctrl: sequencer between RV32M issue and the shared div32 unit.
// Handles DIV/DIVU/REM/REMU, resolving /0 and signed overflow locally.
// Ports:
//   clk, rst                 clock, async active-high reset
//   req_valid/req_ready      request handshake; req_op, req_a, req_b, req_tag
//   flush                    discard current op (highest priority)
//   div_in_en/div_a/div_b/div_signed   issue side of div32
//   div_idle/div_out_en/div_q/div_rem  result side of div32
//   res_valid/res_ready      result handshake; res_data, res_tag
// Optional macro DIV_RESULT_CACHE_EN adds a one-entry result cache.
module div_ctrl #(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [31:0]      req_a,
    input  logic [31:0]      req_b,
    input  logic [TAG_W-1:0] req_tag,
    input  logic             flush,
    output logic             div_in_en,
    output logic [31:0]      div_a,
    output logic [31:0]      div_b,
    output logic             div_signed,
    input  logic             div_idle,
    input  logic             div_out_en,
    input  logic [31:0]      div_q,
    input  logic [31:0]      div_rem,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [31:0]      res_data,
    output logic [TAG_W-1:0] res_tag
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE,
        S_DRAIN
    } state_t;

    state_t state;
    logic   op_rem;

    logic        req_signed;
    logic        b_zero;
    logic        ovf;
    logic        corner;
    logic [31:0] corner_res;

    assign req_signed = ~req_op[0];
    assign b_zero     = (req_b == 32'd0);
    assign ovf        = req_signed
                      && (req_a == 32'h8000_0000)
                      && (req_b == 32'hFFFF_FFFF);
    assign corner     = b_zero || ovf;
    // /0 takes precedence: the overflow pattern cannot have b==0 anyway.
    assign corner_res = b_zero
                      ? (req_op[1] ? req_a : 32'hFFFF_FFFF)
                      : (req_op[1] ? 32'd0 : 32'h8000_0000);

    logic        cache_hit;
    logic [31:0] hit_data;

`ifdef DIV_RESULT_CACHE_EN
    logic        c_valid;
    logic        c_signed;
    logic [31:0] c_a;
    logic [31:0] c_b;
    logic [31:0] c_q;
    logic [31:0] c_rem;
    logic        cache_fill;

    assign cache_hit = c_valid
                     && (c_a == req_a)
                     && (c_b == req_b)
                     && (c_signed == req_signed);
    assign hit_data  = req_op[1] ? c_rem : c_q;

    // Drained completions fill too: div_a/b/signed still hold the
    // operands of the outstanding op until the next accept.
    assign cache_fill = div_out_en
                      && ((state == S_WAIT) || (state == S_DRAIN));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_valid  <= 1'b0;
            c_signed <= 1'b0;
            c_a      <= '0;
            c_b      <= '0;
            c_q      <= '0;
            c_rem    <= '0;
        end else if (cache_fill) begin
            c_valid  <= 1'b1;
            c_signed <= div_signed;
            c_a      <= div_a;
            c_b      <= div_b;
            c_q      <= div_q;
            c_rem    <= div_rem;
        end
    end
`else
    assign cache_hit = 1'b0;
    assign hit_data  = 32'd0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            req_ready  <= 1'b1;
            div_in_en  <= 1'b0;
            div_a      <= '0;
            div_b      <= '0;
            div_signed <= 1'b0;
            res_valid  <= 1'b0;
            res_data   <= '0;
            res_tag    <= '0;
            op_rem     <= 1'b0;
        end else begin
            div_in_en <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_valid && !flush) begin
                        op_rem     <= req_op[1];
                        res_tag    <= req_tag;
                        div_a      <= req_a;
                        div_b      <= req_b;
                        div_signed <= req_signed;
                        req_ready  <= 1'b0;
                        if (corner) begin
                            res_data  <= corner_res;
                            res_valid <= 1'b1;
                            state     <= S_DONE;
                        end else if (cache_hit) begin
                            res_data  <= hit_data;
                            res_valid <= 1'b1;
                            state     <= S_DONE;
                        end else begin
                            state <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    if (flush) begin
                        state     <= S_IDLE;
                        req_ready <= 1'b1;
                    end else if (div_idle) begin
                        div_in_en <= 1'b1;
                        state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (flush) begin
                        // A result landing with the flush needs no drain.
                        if (div_out_en) begin
                            state     <= S_IDLE;
                            req_ready <= 1'b1;
                        end else begin
                            state <= S_DRAIN;
                        end
                    end else if (div_out_en) begin
                        res_data  <= op_rem ? div_rem : div_q;
                        res_valid <= 1'b1;
                        state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (flush || res_ready) begin
                        res_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                S_DRAIN: begin
                    if (div_out_en) begin
                        req_ready <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    req_ready <= 1'b1;
                    res_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_ctrl.sv
// Directed self-checking bench for div_ctrl with a behavioural div32.
// One task per scenario; expected values are hand-computed constants.
module tb_div_ctrl;

    localparam int LAT = 4;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [3:0]  req_tag;
    logic        flush;
    logic        div_in_en;
    logic [31:0] div_a;
    logic [31:0] div_b;
    logic        div_signed;
    logic        div_idle;
    logic        div_out_en;
    logic [31:0] div_q;
    logic [31:0] div_rem;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic [3:0]  res_tag;

    int checks;
    int passed;

    div_ctrl #(.TAG_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_tag   (req_tag),
        .flush     (flush),
        .div_in_en (div_in_en),
        .div_a     (div_a),
        .div_b     (div_b),
        .div_signed(div_signed),
        .div_idle  (div_idle),
        .div_out_en(div_out_en),
        .div_q     (div_q),
        .div_rem   (div_rem),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_tag   (res_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural div32: LAT+1 cycles from sampled start to result pulse.
    logic        busy;
    logic        hold_busy;
    logic        busy_viol;
    int          cnt;
    int          pulses;
    logic        ms;
    logic [31:0] ma;
    logic [31:0] mb;

    assign div_idle = ~busy & ~hold_busy;

    always @(posedge clk) begin
        if (rst) begin
            busy       <= 1'b0;
            cnt        <= 0;
            div_out_en <= 1'b0;
            div_q      <= '0;
            div_rem    <= '0;
        end else begin
            div_out_en <= 1'b0;
            if (div_in_en && !div_idle)
                busy_viol <= 1'b1;
            if (div_in_en)
                pulses <= pulses + 1;
            if (busy) begin
                if (cnt == 0) begin
                    busy       <= 1'b0;
                    div_out_en <= 1'b1;
                    if (ms) begin
                        div_q   <= $signed(ma) / $signed(mb);
                        div_rem <= $signed(ma) % $signed(mb);
                    end else begin
                        div_q   <= ma / mb;
                        div_rem <= ma % mb;
                    end
                end else begin
                    cnt <= cnt - 1;
                end
            end else if (div_in_en) begin
                busy <= 1'b1;
                cnt  <= LAT;
                ma   <= div_a;
                mb   <= div_b;
                ms   <= div_signed;
            end
        end
    end

    task automatic run_op(
        input  logic [1:0]  op,
        input  logic [31:0] a,
        input  logic [31:0] b,
        input  logic [3:0]  tag,
        output logic [31:0] d,
        output logic [3:0]  t,
        output int          lat,
        output int          np
    );
        int p0;
        p0        = pulses;
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_tag   = tag;
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!res_valid && lat < 80) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (res_valid !== 1'b1)
            $display("FAIL op_timeout res_valid=%b want 1", res_valid);
        else
            passed++;
        d  = res_data;
        t  = res_tag;
        np = pulses - p0;
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    task automatic test_reset;
        checks++;
        if (req_ready !== 1'b1)
            $display("FAIL rst_req_ready got %b want 1", req_ready);
        else passed++;
        checks++;
        if (res_valid !== 1'b0)
            $display("FAIL rst_res_valid got %b want 0", res_valid);
        else passed++;
        checks++;
        if (div_in_en !== 1'b0)
            $display("FAIL rst_div_in_en got %b want 0", div_in_en);
        else passed++;
        checks++;
        if ({res_data, res_tag, div_a, div_b, div_signed} !== '0)
            $display("FAIL rst_outputs data=%h tag=%h a=%h b=%h s=%b want 0",
                     res_data, res_tag, div_a, div_b, div_signed);
        else passed++;
    endtask

    task automatic test_issue;
        logic [31:0] d;
        logic [3:0]  t;
        int          lat;
        int          np;
        run_op(2'b00, 32'd100, 32'd7, 4'd3, d, t, lat, np);
        checks++;
        if (d !== 32'd14 || t !== 4'd3)
            $display("FAIL div_100_7 got %h/%h want 0000000e/3", d, t);
        else passed++;
        checks++;
        if (np !== 1)
            $display("FAIL div_100_7_pulses got %0d want 1", np);
        else passed++;
        checks++;
        if (div_signed !== 1'b1)
            $display("FAIL div_signed_div got %b want 1", div_signed);
        else passed++;
        run_op(2'b10, 32'd100, 32'd7, 4'd4, d, t, lat, np);
        checks++;
        if (d !== 32'd2 || t !== 4'd4)
            $display("FAIL rem_100_7 got %h/%h want 00000002/4", d, t);
        else passed++;
`ifdef DIV_RESULT_CACHE_EN
        checks++;
        if (np !== 0 || lat !== 1)
            $display("FAIL rem_cache_hit pulses=%0d lat=%0d want 0/1", np, lat);
        else passed++;
`else
        checks++;
        if (np !== 1)
            $display("FAIL rem_100_7_pulses got %0d want 1", np);
        else passed++;
`endif
    endtask

    task automatic test_div_zero;
        logic [31:0] d;
        logic [3:0]  t;
        int          lat;
        int          np;
        run_op(2'b01, 32'd5, 32'd0, 4'd5, d, t, lat, np);
        checks++;
        if (d !== 32'hFFFF_FFFF || np !== 0 || lat !== 1)
            $display("FAIL divu_5_0 got d=%h pulses=%0d lat=%0d want ffffffff/0/1",
                     d, np, lat);
        else passed++;
        checks++;
        if (div_signed !== 1'b0)
            $display("FAIL div_signed_divu got %b want 0", div_signed);
        else passed++;
        run_op(2'b11, 32'd5, 32'd0, 4'd6, d, t, lat, np);
        checks++;
        if (d !== 32'd5 || t !== 4'd6 || np !== 0)
            $display("FAIL remu_5_0 got d=%h t=%h pulses=%0d want 5/6/0", d, t, np);
        else passed++;
    endtask

    task automatic test_overflow;
        logic [31:0] d;
        logic [3:0]  t;
        int          lat;
        int          np;
        run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 4'd7, d, t, lat, np);
        checks++;
        if (d !== 32'h8000_0000 || np !== 0 || lat !== 1)
            $display("FAIL div_ovf got d=%h pulses=%0d lat=%0d want 80000000/0/1",
                     d, np, lat);
        else passed++;
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 4'd8, d, t, lat, np);
        checks++;
        if (d !== 32'd0 || np !== 0)
            $display("FAIL rem_ovf got d=%h pulses=%0d want 0/0", d, np);
        else passed++;
    endtask

    task automatic test_signed;
        logic [31:0] d;
        logic [3:0]  t;
        int          lat;
        int          np;
        run_op(2'b00, 32'hFFFF_FFF9, 32'd2, 4'd1, d, t, lat, np);
        checks++;
        if (d !== 32'hFFFF_FFFD)
            $display("FAIL div_m7_2 got %h want fffffffd", d);
        else passed++;
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 4'd2, d, t, lat, np);
        checks++;
        if (d !== 32'hFFFF_FFFF)
            $display("FAIL rem_m7_2 got %h want ffffffff", d);
        else passed++;
        run_op(2'b01, 32'hFFFF_FFF9, 32'd2, 4'd3, d, t, lat, np);
        checks++;
        if (d !== 32'h7FFF_FFFC || np !== 1)
            $display("FAIL divu_fff9_2 got d=%h pulses=%0d want 7ffffffc/1", d, np);
        else passed++;
    endtask

    task automatic test_flush_wait;
        logic [31:0] d;
        logic [3:0]  t;
        int          lat;
        int          np;
        logic        seen;
        req_valid = 1'b1;
        req_op    = 2'b00;
        req_a     = 32'd50;
        req_b     = 32'd5;
        req_tag   = 4'd1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (div_in_en !== 1'b1)
            $display("FAIL flush_wait_issue got %b want 1", div_in_en);
        else passed++;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            checks++;
            if (res_valid !== 1'b0 || req_ready !== 1'b0)
                $display("FAIL drain_hold res_valid=%b req_ready=%b want 0/0",
                         res_valid, req_ready);
            else passed++;
            if (div_out_en) seen = 1'b1;
            else @(negedge clk);
        end
        checks++;
        if (seen !== 1'b1)
            $display("FAIL drain_timeout div_out_en seen=%b want 1", seen);
        else passed++;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || res_valid !== 1'b0)
            $display("FAIL drain_exit req_ready=%b res_valid=%b want 1/0",
                     req_ready, res_valid);
        else passed++;
        run_op(2'b00, 32'd9, 32'd3, 4'd2, d, t, lat, np);
        checks++;
        if (d !== 32'd3 || t !== 4'd2)
            $display("FAIL after_drain got %h/%h want 3/2", d, t);
        else passed++;
    endtask

    task automatic test_hold;
        int n;
        req_valid = 1'b1;
        req_op    = 2'b00;
        req_a     = 32'd100;
        req_b     = 32'd3;
        req_tag   = 4'd9;
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (!res_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (res_valid !== 1'b1 || res_data !== 32'd33 ||
                res_tag !== 4'd9 || req_ready !== 1'b0)
                $display("FAIL hold v=%b d=%h t=%h rr=%b want 1/21/9/0",
                         res_valid, res_data, res_tag, req_ready);
            else passed++;
            @(negedge clk);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        checks++;
        if (res_valid !== 1'b0 || req_ready !== 1'b1)
            $display("FAIL hold_release v=%b rr=%b want 0/1", res_valid, req_ready);
        else passed++;
    endtask

    task automatic test_flush_other;
        int p0;
        // Flush in IDLE blocks the accept.
        req_valid = 1'b1;
        req_op    = 2'b01;
        req_a     = 32'd5;
        req_b     = 32'd0;
        req_tag   = 4'd2;
        flush     = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        flush     = 1'b0;
        checks++;
        if (res_valid !== 1'b0 || req_ready !== 1'b1)
            $display("FAIL flush_idle v=%b rr=%b want 0/1", res_valid, req_ready);
        else passed++;
        // Flush in DONE drops the result.
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        flush     = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checks++;
        if (res_valid !== 1'b0 || req_ready !== 1'b1)
            $display("FAIL flush_done v=%b rr=%b want 0/1", res_valid, req_ready);
        else passed++;
        // Flush in ISSUE while div32 is busy: nothing is issued.
        p0        = pulses;
        hold_busy = 1'b1;
        req_valid = 1'b1;
        req_op    = 2'b00;
        req_a     = 32'd20;
        req_b     = 32'd4;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush     = 1'b0;
        hold_busy = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (pulses - p0 !== 0 || req_ready !== 1'b1 || res_valid !== 1'b0)
            $display("FAIL flush_issue pulses=%0d rr=%b v=%b want 0/1/0",
                     pulses - p0, req_ready, res_valid);
        else passed++;
    endtask

    task automatic test_busy_div;
        logic [31:0] d;
        logic [3:0]  t;
        int          lat;
        int          np;
        int          p0;
        p0        = pulses;
        hold_busy = 1'b1;
        req_valid = 1'b1;
        req_op    = 2'b00;
        req_a     = 32'd20;
        req_b     = 32'd4;
        req_tag   = 4'hA;
        @(negedge clk);
        req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (div_in_en !== 1'b0)
                $display("FAIL busy_no_issue got %b want 0", div_in_en);
            else passed++;
        end
        hold_busy = 1'b0;
        lat = 0;
        while (!res_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (res_data !== 32'd5 || res_tag !== 4'hA || pulses - p0 !== 1)
            $display("FAIL busy_result d=%h t=%h pulses=%0d want 5/a/1",
                     res_data, res_tag, pulses - p0);
        else passed++;
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        run_op(2'b10, 32'd23, 32'd4, 4'hB, d, t, lat, np);
        checks++;
        if (d !== 32'd3 || t !== 4'hB)
            $display("FAIL back_to_back got %h/%h want 3/b", d, t);
        else passed++;
    endtask

    initial begin
        checks    = 0;
        passed    = 0;
        pulses    = 0;
        busy_viol = 1'b0;
        hold_busy = 1'b0;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_op    = 2'b00;
        req_a     = '0;
        req_b     = '0;
        req_tag   = '0;
        flush     = 1'b0;
        res_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        test_reset();
        test_issue();
        test_div_zero();
        test_overflow();
        test_signed();
        test_flush_wait();
        test_hold();
        test_flush_other();
        test_busy_div();
        checks++;
        if (busy_viol !== 1'b0)
            $display("FAIL issue_while_busy got %b want 0", busy_viol);
        else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
